// File: rtl/alu_pkg.sv
// Purpose: shared opcode encoding and flag bit positions for the pipelined ALU.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: op_e (OP_ADD..OP_PASSB, 3-bit fully decoded), FLG_C/FLG_Z/FLG_N/FLG_V
// indices into the 4-bit flag vector, and small opcode classification helpers.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD   = 3'd0,
    OP_ADC   = 3'd1,
    OP_AND   = 3'd2,
    OP_OR    = 3'd3,
    OP_SUB   = 3'd4,
    OP_SBB   = 3'd5,
    OP_XOR   = 3'd6,
    OP_PASSB = 3'd7
  } op_e;

  // Bit positions inside the packed 4-bit flag vector.
  localparam int FLG_C = 0;
  localparam int FLG_Z = 1;
  localparam int FLG_N = 2;
  localparam int FLG_V = 3;
  localparam int NUM_FLAGS = 4;

  // Ops that go through the adder and therefore produce meaningful C/V.
  function automatic logic is_arith(op_e op);
    return (op == OP_ADD) || (op == OP_ADC) || (op == OP_SUB) || (op == OP_SBB);
  endfunction

  // Ops that feed ~B into the adder.
  function automatic logic is_sub(op_e op);
    return (op == OP_SUB) || (op == OP_SBB);
  endfunction

  // Ops that take their carry-in from the chained carry (or in_cin).
  function automatic logic uses_carry(op_e op);
    return (op == OP_ADC) || (op == OP_SBB);
  endfunction

endpackage

// File: rtl/alu_pipe_if.sv
// Purpose: request/response bundle between an ALU client and alu_pipe.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready on the request side, out_valid/out_ready on the result side.
//
// Ports: in_valid/in_a/in_b/in_op/in_cin/in_sat (client -> ALU), in_ready (ALU -> client),
// out_valid/out_data/out_c/out_z/out_n/out_v (ALU -> client), out_ready (client -> ALU).
// master = client side, slave = ALU side.
interface alu_pipe_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [2:0]       in_op;
  logic             in_cin;
  logic             in_sat;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_c;
  logic             out_z;
  logic             out_n;
  logic             out_v;

  modport master (
    output in_valid, in_a, in_b, in_op, in_cin, in_sat, out_ready,
    input  in_ready, out_valid, out_data, out_c, out_z, out_n, out_v
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, in_cin, in_sat, out_ready,
    output in_ready, out_valid, out_data, out_c, out_z, out_n, out_v
  );

endinterface

// File: rtl/alu_pipe_core.sv
// Purpose: combinational WIDTH-bit ALU datapath producing result and C/Z/N/V flags.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when to capture the outputs.
//
// Ports: a, b (operands), op (3-bit opcode), cin (carry for ADC/SBB), sat (saturation request),
// res (result), flags (indexed by FLG_C/FLG_Z/FLG_N/FLG_V).
// Optional feature macro ALU_SAT_EN: when defined, overflowing arithmetic with sat=1 clamps to
// signed max/min; when undefined, sat is ignored and results wrap.
module alu_pipe_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [2:0]           op,
  input  logic                 cin,
  input  logic                 sat,
  output logic [WIDTH-1:0]     res,
  output logic [NUM_FLAGS-1:0] flags
);

  localparam int MSB = WIDTH - 1;
  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  op_e            opc;
  logic           arith;
  logic [WIDTH-1:0] b_eff;
  logic           c_eff;
  logic [WIDTH:0] sum;
  logic           c_out;
  logic           v_out;
  logic [WIDTH-1:0] wrap_res;

  assign opc = op_e'(op);

  // Adder path: SUB/SBB reuse the adder with ~B; SUB forces carry-in 1,
  // ADC/SBB take the supplied carry, ADD starts from 0.
  always_comb begin
    arith = is_arith(opc);
    b_eff = is_sub(opc) ? ~b : b;
    if (uses_carry(opc)) begin
      c_eff = cin;
    end else begin
      c_eff = (opc == OP_SUB);
    end
    sum   = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, c_eff};
    c_out = arith & sum[WIDTH];
    // Signed overflow: adder inputs share a sign but the sum does not.
    v_out = arith & (a[MSB] == b_eff[MSB]) & (sum[MSB] != a[MSB]);
  end

  always_comb begin
    wrap_res = '0;
    case (opc)
      OP_ADD, OP_ADC, OP_SUB, OP_SBB: wrap_res = sum[WIDTH-1:0];
      OP_AND:   wrap_res = a & b;
      OP_OR:    wrap_res = a | b;
      OP_XOR:   wrap_res = a ^ b;
      OP_PASSB: wrap_res = b;
      default:  wrap_res = '0;
    endcase
  end

`ifdef ALU_SAT_EN
  // On overflow the adder inputs share A's sign: A positive means the true
  // result exceeded SMAX, A negative means it fell below SMIN.
  always_comb begin
    res = wrap_res;
    if (sat && v_out) begin
      res = a[MSB] ? SMIN : SMAX;
    end
  end
`else
  logic unused_sat;
  logic [2*WIDTH-1:0] unused_clamp;
  assign unused_sat   = sat;
  assign unused_clamp = {SMAX, SMIN};
  assign res          = wrap_res;
`endif

  // Z/N always describe the value actually delivered (post-clamp).
  always_comb begin
    flags        = '0;
    flags[FLG_C] = c_out;
    flags[FLG_Z] = (res == '0);
    flags[FLG_N] = res[MSB];
    flags[FLG_V] = v_out;
  end

endmodule

// File: rtl/alu_pipe.sv
// Purpose: two-stage pipelined ALU with chained carry register for multi-word ADC/SBB.
// Latency: 2 cycles accept -> out_valid; throughput 1 op/cycle.
// Backpressure: out_ready low stalls S2 then S1; in_ready drops only when both stages hold data.
//
// Ports: clk, rst (synchronous, active-high); bus (alu_pipe_if.slave) carrying the in_* request
// handshake and the out_* result handshake with C/Z/N/V flags.
// Parameters: WIDTH (>=2) operand width; CARRY_CHAIN 1 = ADC/SBB use the internal carry
// register, 0 = they use in_cin. Optional macro ALU_SAT_EN enables signed saturation (see core).
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int CARRY_CHAIN = 1
) (
  input logic           clk,
  input logic           rst,
  alu_pipe_if.slave     bus
);

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             cin;
    logic             sat;
  } req_t;

  typedef struct packed {
    logic [WIDTH-1:0]     data;
    logic [NUM_FLAGS-1:0] flags;
  } rsp_t;

  req_t s1_q;
  logic s1_vld;
  rsp_t s2_q;
  logic s2_vld;
  logic carry_q;

  logic accept;
  logic xfer;
  logic core_cin;
  rsp_t core_rsp;

  // S1 may advance when S2 is empty or draining this cycle; a new op can
  // enter whenever S1 is empty or about to move on.
  assign xfer          = s1_vld && (!s2_vld || bus.out_ready);
  assign bus.in_ready  = !s1_vld || !s2_vld || bus.out_ready;
  assign accept        = bus.in_valid && bus.in_ready;

  assign core_cin = (CARRY_CHAIN != 0) ? carry_q : s1_q.cin;

  alu_pipe_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a     (s1_q.a),
    .b     (s1_q.b),
    .op    (s1_q.op),
    .cin   (core_cin),
    .sat   (s1_q.sat),
    .res   (core_rsp.data),
    .flags (core_rsp.flags)
  );

  // Stage 1: operand capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld <= 1'b0;
      s1_q   <= '0;
    end else begin
      if (accept) begin
        s1_vld  <= 1'b1;
        s1_q.a   <= bus.in_a;
        s1_q.b   <= bus.in_b;
        s1_q.op  <= bus.in_op;
        s1_q.cin <= bus.in_cin;
        s1_q.sat <= bus.in_sat;
      end else if (xfer) begin
        s1_vld <= 1'b0;
      end
    end
  end

  // Stage 2: result/flags hold, plus the carry chain. The carry register
  // updates on the same edge the op leaves S1, so the next op in S1 sees it
  // without a bubble. Logic ops load C=0 into the chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_vld  <= 1'b0;
      s2_q    <= '0;
      carry_q <= 1'b0;
    end else begin
      if (xfer) begin
        s2_vld  <= 1'b1;
        s2_q    <= core_rsp;
        carry_q <= core_rsp.flags[FLG_C];
      end else if (bus.out_ready) begin
        s2_vld <= 1'b0;
      end
    end
  end

  assign bus.out_valid = s2_vld;
  assign bus.out_data  = s2_q.data;
  assign bus.out_c     = s2_q.flags[FLG_C];
  assign bus.out_z     = s2_q.flags[FLG_Z];
  assign bus.out_n     = s2_q.flags[FLG_N];
  assign bus.out_v     = s2_q.flags[FLG_V];

endmodule
